spi_wb_bridge: RTL and testbench

- SPI-slave to Wishbone-master bridge: an external SPI host (debugger or test MCU) issues 32-bit word reads and writes onto the on-chip Wishbone bus.
- It is the inverse of the chip's SPI-master memory controllers. The chip is the SPI responder and the bus initiator.
- It sits beside the CPU as a second bus master for bring-up, program load and memory inspection. Arbitration is external to this block.

---
 rtl/spi_wb_bridge.sv | 237 +++++++++++++++++++++++
 tb/tb_spi_wb_bridge.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_wb_bridge.sv
// SPI-slave (mode 0) to Wishbone-master bridge for 32-bit word reads and writes.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no frame; wait for cs_n to fall
// S_CMD   | shifting in the 8-bit command
// S_ADDR  | shifting in the 32-bit address (read issues at its end)
// S_WDATA | shifting in 32-bit write data (write issues at its end)
// S_DUMMY | dummy bit times while the read cycle runs on the bus
// S_RDATA | shifting 32 bits of read data out on miso
// S_HOLD  | frame finished or rejected; ignore sclk until cs_n rises
module spi_wb_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int DUMMY_BITS  = 8,
  parameter int WB_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sclk_i,
  input  logic        spi_cs_n_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        busy_o,
  output logic        err_o
);

  localparam int CNT_W = 8;
  localparam int TO_W  = $clog2(WB_TIMEOUT + 1);
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA, S_HOLD
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic sclk_prev, cs_prev;
  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [CNT_W-1:0] bit_cnt;
  logic             last_bit, field_done;
  logic [30:0]      rx_sh;
  logic [7:0]       cmd_q, cmd_in;
  logic [31:0]      word_in, adr_q;
  logic [31:0]      tx_sh;
  logic             tx_loaded;

  logic             cyc, we, err;
  logic [31:0]      adr, dat;
  logic [TO_W-1:0]  to_cnt;
  logic [31:0]      rd_data;
  logic             rd_valid, rd_owned;
  logic             wr_req, rd_req, late_load;

  // Synchronise the asynchronous SPI pins and keep the previous synced level for edge detect.
  // cs_n idles high so the chain resets to 1 to avoid a false frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  assign cs_fall   = ~cs_s & cs_prev;

  assign cmd_in  = {rx_sh[6:0], mosi_s};
  assign word_in = {rx_sh, mosi_s};

  // Flag the final bit of the current field.
  always_comb begin
    last_bit = 1'b0;
    case (state_q)
      S_CMD:                    last_bit = (bit_cnt == CNT_W'(7));
      S_ADDR, S_WDATA, S_RDATA: last_bit = (bit_cnt == CNT_W'(31));
      S_DUMMY:                  last_bit = (bit_cnt == CNT_W'(DUMMY_BITS - 1));
      default:                  last_bit = 1'b0;
    endcase
  end

  assign field_done = sclk_rise & last_bit;
  assign wr_req     = (state_q == S_WDATA) & field_done & ~cs_rise;
  assign rd_req     = (state_q == S_ADDR) & field_done & ~cs_rise & (cmd_q == CMD_READ);
  assign late_load  = (state_q == S_RDATA) & sclk_fall & ~tx_loaded & ~(rd_valid & rd_owned);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; cs_n rising always ends the frame.
  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (cs_fall) state_d = S_CMD;
        S_CMD:   if (field_done)
                   state_d = (cmd_in == CMD_WRITE || cmd_in == CMD_READ) ? S_ADDR : S_HOLD;
        S_ADDR:  if (field_done)
                   state_d = (cmd_q == CMD_WRITE) ? S_WDATA :
                             ((DUMMY_BITS == 0) ? S_RDATA : S_DUMMY);
        S_WDATA: if (field_done) state_d = S_HOLD;
        S_DUMMY: if (field_done) state_d = S_RDATA;
        S_RDATA: if (field_done) state_d = S_HOLD;
        S_HOLD:  state_d = S_HOLD;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Frame datapath: bit counter, receive shifter, captured fields and transmit shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      rx_sh     <= '0;
      cmd_q     <= '0;
      adr_q     <= '0;
      tx_sh     <= '0;
      tx_loaded <= 1'b0;
    end else begin
      if (state_d != state_q)
        bit_cnt <= '0;
      else if (sclk_rise && state_q != S_IDLE && state_q != S_HOLD)
        bit_cnt <= bit_cnt + 1'b1;

      if (sclk_rise && (state_q == S_CMD || state_q == S_ADDR || state_q == S_WDATA))
        rx_sh <= word_in[30:0];

      if (state_q == S_CMD && field_done)  cmd_q <= cmd_in;
      if (state_q == S_ADDR && field_done) adr_q <= word_in;

      // First falling edge in RDATA loads the word (or all-ones if the bus has not
      // answered yet); each later falling edge presents the next bit.
      if (state_q != S_RDATA) begin
        tx_sh     <= '0;
        tx_loaded <= 1'b0;
      end else if (sclk_fall) begin
        tx_loaded <= 1'b1;
        if (tx_loaded)                 tx_sh <= {tx_sh[30:0], 1'b0};
        else if (rd_valid && rd_owned) tx_sh <= rd_data;
        else                           tx_sh <= '1;
      end
    end
  end

  // Wishbone master: issue, hold until ack, time out, and report errors.
  // rd_owned marks read data that belongs to the current frame, so a stale
  // result from an earlier frame is never shifted out.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc      <= 1'b0;
      we       <= 1'b0;
      adr      <= '0;
      dat      <= '0;
      to_cnt   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_owned <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= late_load;
      if (cs_fall) rd_owned <= 1'b0;

      if (cyc) begin
        if (wb_ack_i) begin
          cyc <= 1'b0;
          if (!we) begin
            rd_data  <= wb_dat_i;
            rd_valid <= 1'b1;
          end
        end else if (to_cnt == '0) begin
          cyc <= 1'b0;
          err <= 1'b1;
          if (!we) begin
            rd_data  <= '1;
            rd_valid <= 1'b1;
          end
        end else begin
          to_cnt <= to_cnt - 1'b1;
        end
      end

      if (wr_req || rd_req) begin
        if (cyc) begin
          err <= 1'b1;
        end else begin
          cyc      <= 1'b1;
          we       <= wr_req;
          adr      <= wr_req ? adr_q : word_in;
          if (wr_req) dat <= word_in;
          to_cnt   <= TO_W'(WB_TIMEOUT - 1);
          rd_valid <= 1'b0;
          rd_owned <= rd_req;
        end
      end
    end
  end

  assign wb_cyc_o   = cyc;
  assign wb_stb_o   = cyc;
  assign wb_we_o    = we;
  assign wb_sel_o   = cyc ? 4'hF : 4'h0;
  assign wb_adr_o   = adr;
  assign wb_dat_o   = dat;
  assign busy_o     = cyc;
  assign err_o      = err;
  assign spi_miso_o = (state_q == S_RDATA) & tx_loaded & tx_sh[31];

endmodule

// File: tb/tb_spi_wb_bridge.sv
// Bench for spi_wb_bridge: a bit-banged SPI host, a Wishbone slave with
// programmable ack latency, a table of directed transactions, a reset
// sequence, and randomized transactions checked against a frame-level model.
module tb_spi_wb_bridge;

  localparam int HALF     = 8;                 // clk periods per sclk half period
  localparam int WB_TO    = 255;
  localparam int READ_GAP = 8 * 2 * HALF + HALF; // clk from read issue to first read-data load

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_sclk_i, spi_cs_n_i, spi_mosi_i, spi_miso_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, busy_o, err_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;

  spi_wb_bridge dut (
    .clk(clk), .rst(rst),
    .spi_sclk_i(spi_sclk_i), .spi_cs_n_i(spi_cs_n_i),
    .spi_mosi_i(spi_mosi_i), .spi_miso_o(spi_miso_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          nbits;
    int          delay;      // ack latency in clk; -1 = never ack
    logic [31:0] sdata;
    int          exp_cycles;
    logic        exp_we;
    logic [31:0] exp_adr;
    logic [31:0] exp_dat;
    int          exp_len;
    int          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  int n_vec = 0;
  int n_miss = 0;

  // Slave and monitor state; written only by the negedge process below.
  int          slave_delay = 0;
  logic [31:0] slave_data = '0;
  bit          spurious = 1'b0;
  int          hi_cnt = 0, cur_len = 0, last_len = 0;
  int          cyc_starts = 0, err_total = 0, busy_bad = 0;
  logic        cyc_prev = 1'b0, last_we = 1'b0;
  logic [3:0]  last_sel = '0;
  logic [31:0] last_adr = '0, last_dat = '0;

  // Wishbone slave and bus monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (wb_cyc_o) begin
      if (!cyc_prev) begin
        cyc_starts++;
        last_we  = wb_we_o;
        last_adr = wb_adr_o;
        last_dat = wb_dat_o;
        last_sel = wb_sel_o;
        cur_len  = 0;
      end
      cur_len++;
    end else if (cyc_prev) begin
      last_len = cur_len;
    end
    cyc_prev = wb_cyc_o;
    if (err_o) err_total++;
    if (busy_o !== wb_cyc_o || wb_stb_o !== wb_cyc_o) busy_bad++;
    if (wb_cyc_o) begin
      hi_cnt++;
      wb_ack_i = (slave_delay >= 0 && hi_cnt == slave_delay + 1);
    end else begin
      hi_cnt   = 0;
      wb_ack_i = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    wb_dat_i = (wb_ack_i && wb_cyc_o) ? slave_data : $urandom;
  end

  task automatic check(input string tag, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s.%s: got %h expected %h", tag, name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] cmd, input logic [31:0] addr, wdata,
                              input int nbits, delay, input logic [31:0] sdata,
                              input int ecyc, input logic ewe, input logic [31:0] eadr, edat,
                              input int elen, eerr, input logic [31:0] erd);
    vec_t v;
    v.cmd = cmd; v.addr = addr; v.wdata = wdata; v.nbits = nbits; v.delay = delay;
    v.sdata = sdata; v.exp_cycles = ecyc; v.exp_we = ewe; v.exp_adr = eadr;
    v.exp_dat = edat; v.exp_len = elen; v.exp_err = eerr; v.exp_rdata = erd;
    return v;
  endfunction

  // Frame-level reference: which frames reach the bus, how long the cycle
  // lasts, whether the host sees real data, and how many errors result.
  function automatic vec_t model(input vec_t v);
    vec_t m;
    bit is_wr, is_rd, issued, no_ack, late;
    int len;
    m      = v;
    is_wr  = (v.cmd == 8'h02);
    is_rd  = (v.cmd == 8'h03);
    issued = (is_wr && v.nbits >= 72) || (is_rd && v.nbits >= 40);
    no_ack = (v.delay < 0) || (v.delay + 1 > WB_TO);
    len    = no_ack ? WB_TO : v.delay + 1;
    late   = issued && is_rd && v.nbits >= 48 && len > READ_GAP;
    m.exp_cycles = issued ? 1 : 0;
    m.exp_we     = is_wr;
    m.exp_adr    = v.addr;
    m.exp_dat    = v.wdata;
    m.exp_len    = len;
    m.exp_err    = (issued && no_ack ? 1 : 0) + (late ? 1 : 0);
    m.exp_rdata  = (late || no_ack) ? 32'hFFFF_FFFF : v.sdata;
    return m;
  endfunction

  // Mode-0 SPI host: mosi set while sclk is low, miso sampled just before each rising edge.
  task automatic spi_frame(input logic [7:0] cmd, input logic [31:0] addr, wdata,
                           input int nbits, output logic [31:0] rdata, output int miso_ones);
    logic [79:0] stream;
    stream    = {cmd, addr, (cmd == 8'h03) ? 32'h0 : wdata, 8'h00};
    rdata     = '0;
    miso_ones = 0;
    @(negedge clk);
    spi_cs_n_i = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi_i = (i < 80) ? stream[79 - i] : 1'b0;
      repeat (HALF) @(negedge clk);
      if (cmd == 8'h03 && i >= 48 && i < 80) rdata[79 - i] = spi_miso_o;
      else if (spi_miso_o) miso_ones++;
      spi_sclk_i = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sclk_i = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    spi_cs_n_i = 1'b1;
    spi_mosi_i = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int          c0, e0, ones, waited;
    logic [31:0] rd;
    slave_delay = v.delay;
    slave_data  = v.sdata;
    c0 = cyc_starts;
    e0 = err_total;
    spi_frame(v.cmd, v.addr, v.wdata, v.nbits, rd, ones);
    waited = 0;
    while (wb_cyc_o && waited < 600) begin
      @(negedge clk);
      waited++;
    end
    check(tag, "cyc_closed", 32'(wb_cyc_o), 32'd0);
    repeat (4) @(negedge clk);
    check(tag, "cycles", 32'(cyc_starts - c0), 32'(v.exp_cycles));
    if (v.exp_cycles == 1) begin
      check(tag, "we", 32'(last_we), 32'(v.exp_we));
      check(tag, "adr", last_adr, v.exp_adr);
      check(tag, "sel", 32'(last_sel), 32'hF);
      check(tag, "cyc_len", 32'(last_len), 32'(v.exp_len));
      if (v.exp_we) check(tag, "dat", last_dat, v.exp_dat);
      else          check(tag, "rdata", rd, v.exp_rdata);
    end
    check(tag, "err_pulses", 32'(err_total - e0), 32'(v.exp_err));
    check(tag, "miso_idle", 32'(ones), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[9];
    vec_t        v;
    logic [31:0] rd;
    int          ones;

    tbl[0] = mk(8'h02, 32'h1000_0000, 32'h0000_000A, 72,   2, 32'h0,
                1, 1'b1, 32'h1000_0000, 32'h0000_000A,   3, 0, 32'h0);
    tbl[1] = mk(8'h03, 32'h4000_0004, 32'h0,         80,   3, 32'hCAFE_F00D,
                1, 1'b0, 32'h4000_0004, 32'h0,           4, 0, 32'hCAFE_F00D);
    tbl[2] = mk(8'h03, 32'h4000_0004, 32'h0,         80, 200, 32'hCAFE_F00D,
                1, 1'b0, 32'h4000_0004, 32'h0,         201, 1, 32'hFFFF_FFFF);
    tbl[3] = mk(8'h02, 32'h3000_0000, 32'hDEAD_BEEF, 72,  -1, 32'h0,
                1, 1'b1, 32'h3000_0000, 32'hDEAD_BEEF, 255, 1, 32'h0);
    tbl[4] = mk(8'h02, 32'h1000_0000, 32'h0,         28,   0, 32'h0,
                0, 1'b0, 32'h0, 32'h0, 0, 0, 32'h0);
    tbl[5] = mk(8'hA5, 32'hFFFF_FFFF, 32'h5555_AAAA, 72,   0, 32'h0,
                0, 1'b0, 32'h0, 32'h0, 0, 0, 32'h0);
    tbl[6] = mk(8'h02, 32'h2000_0000, 32'h5A5A_A5A5, 72,   0, 32'h0,
                1, 1'b1, 32'h2000_0000, 32'h5A5A_A5A5,   1, 0, 32'h0);
    tbl[7] = mk(8'h03, 32'h5000_0008, 32'h0,         80,  -1, 32'h1234_5678,
                1, 1'b0, 32'h5000_0008, 32'h0,         255, 2, 32'hFFFF_FFFF);
    tbl[8] = mk(8'h02, 32'h1000_0000, 32'h1111_1111, 60,   0, 32'h0,
                0, 1'b0, 32'h0, 32'h0, 0, 0, 32'h0);

    rst = 1'b1;
    spi_cs_n_i = 1'b1;
    spi_sclk_i = 1'b0;
    spi_mosi_i = 1'b0;
    repeat (5) @(negedge clk);
    check("reset", "ctrl", 32'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, spi_miso_o, busy_o, err_o}), 32'd0);
    check("reset", "adr", wb_adr_o, 32'd0);
    check("reset", "dat", wb_dat_o, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 9; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

    // Reset while a write cycle is outstanding, then a read must still work.
    slave_delay = -1;
    spi_frame(8'h02, 32'h6000_0000, 32'h0BAD_F00D, 72, rd, ones);
    repeat (10) @(negedge clk);
    check("rst_mid", "cyc_before", 32'(wb_cyc_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid", "cyc_stb_miso", 32'({wb_cyc_o, wb_stb_o, spi_miso_o}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    run_txn(mk(8'h03, 32'h8000_0000, 32'h0, 80, 5, 32'h1357_2468,
               1, 1'b0, 32'h8000_0000, 32'h0, 6, 0, 32'h1357_2468), "post_rst");

    // Randomized frames with idle-time spurious acks.
    spurious = 1'b1;
    for (int i = 0; i < 10; i++) begin
      int sel, cls;
      sel = $urandom_range(0, 4);
      cls = $urandom_range(0, 2);
      v.cmd   = (sel < 2) ? 8'h02 : (sel < 4) ? 8'h03 : 8'($urandom_range(4, 255));
      v.addr  = $urandom;
      v.wdata = $urandom;
      v.sdata = $urandom;
      v.delay = (cls == 0) ? $urandom_range(0, 100) : (cls == 1) ? $urandom_range(170, 250) : -1;
      if ($urandom_range(0, 4) == 0) v.nbits = $urandom_range(1, 39);
      else v.nbits = (v.cmd == 8'h03) ? 80 : 72;
      run_txn(model(v), $sformatf("rnd%0d", i));
    end

    check("global", "busy_stb_track_cyc", 32'(busy_bad), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
